// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of one shared UART transmit engine.
// Packets keep the grant until LAST; a watchdog clears stalled owners.
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               CLK50M,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [8*N_REQ-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]   REQ_LAST,
  output logic [N_REQ-1:0]   REQ_READY,
  output logic [N_REQ-1:0]   GRANT,
  output logic               TX_START,
  output logic [7:0]         TX_DATA,
  input  logic               TX_BUSY,
  input  logic               TX_DONE,
  output logic               TIMEOUT_ERR
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE, LOAD, SEND, WAIT
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    own, own_n;
  logic [IW-1:0]    pick;
  logic             last_q, last_n;
  logic [WW-1:0]    wd, wd_n;
  logic [N_REQ-1:0] grant_n;
  logic             start_n;
  logic             err_n;
  logic [7:0]       data_n;
  logic             found;
  logic             hs;
  logic             wd_lim;

  // first valid requester after the last owner, wrapping
  always_comb begin
    int idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && REQ_VALID[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign REQ_READY = (state == LOAD && !TX_BUSY)
                   ? (ONE << own) : '0;
  assign hs     = (state == LOAD) && !TX_BUSY
                && REQ_VALID[own];
  assign wd_lim = (wd == WW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    own_n   = own;
    last_n  = last_q;
    wd_n    = wd;
    grant_n = GRANT;
    start_n = 1'b0;
    data_n  = TX_DATA;
    err_n   = TIMEOUT_ERR;
    unique case (state)
      IDLE: begin
        if (found) begin
          own_n   = pick;
          grant_n = ONE << pick;
          wd_n    = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          data_n  = REQ_DATA[{own, 3'b000} +: 8];
          last_n  = REQ_LAST[own];
          start_n = 1'b1;
          state_n = SEND;
        end else if (wd_lim) begin
          err_n   = 1'b1;
          ptr_n   = own;
          grant_n = '0;
          state_n = IDLE;
        end else begin
          wd_n = wd + WW'(1);
        end
      end
      SEND: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // a done on the limit cycle still counts as success
        if (TX_DONE) begin
          if (last_q) begin
            ptr_n   = own;
            grant_n = '0;
            state_n = IDLE;
          end else begin
            wd_n    = '0;
            state_n = LOAD;
          end
        end else if (wd_lim) begin
          err_n   = 1'b1;
          ptr_n   = own;
          grant_n = '0;
          state_n = IDLE;
        end else begin
          wd_n = wd + WW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      ptr         <= IW'(N_REQ - 1);
      own         <= '0;
      last_q      <= 1'b0;
      wd          <= '0;
      GRANT       <= '0;
      TX_START    <= 1'b0;
      TX_DATA     <= 8'h00;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      own         <= own_n;
      last_q      <= last_n;
      wd          <= wd_n;
      GRANT       <= grant_n;
      TX_START    <= start_n;
      TX_DATA     <= data_n;
      TIMEOUT_ERR <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter
// against a transaction-level owner/byte model and a simple tx engine.
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic           timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .CLK50M     (clk),
    .RST_N      (rst_n),
    .REQ_VALID  (req_valid),
    .REQ_DATA   (req_data),
    .REQ_LAST   (req_last),
    .REQ_READY  (req_ready),
    .GRANT      (grant),
    .TX_START   (tx_start),
    .TX_DATA    (tx_data),
    .TX_BUSY    (tx_busy),
    .TX_DONE    (tx_done),
    .TIMEOUT_ERR(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // requester byte fifos: {last, data}
  logic [8:0] fifo [N][64];
  int head [N];
  int tail [N];

  // model of arbiter-visible behaviour
  int         m_owner;
  int         m_ptr;
  int         m_stall;
  bit         m_want;
  bit         m_start;
  bit         m_inflight;
  bit         m_last;
  bit         m_err;
  logic [7:0] m_data;

  // transmit engine
  int eng_cnt;
  int lat_fix;
  bit rand_lat;
  bit silent;
  bit noise;
  bit spur;
  bit p_busy;
  bit p_done;

  logic [7:0] sent[$];
  logic [N-1:0] one = 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic last,
                      input logic [7:0] d);
    fifo[r][tail[r] % 64] = {last, d};
    tail[r]++;
  endtask

  function automatic bit empty_all();
    for (int i = 0; i < N; i++)
      if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [8:0] e;
      e = (head[i] != tail[i]) ? fifo[i][head[i] % 64] : 9'h0;
      req_valid[i]       = (head[i] != tail[i]);
      req_data[8*i +: 8] = e[7:0];
      req_last[i]        = e[8];
    end
    tx_busy = p_busy;
    tx_done = p_done;
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = N - 1;
    m_stall    = 0;
    m_want     = 0;
    m_start    = 0;
    m_inflight = 0;
    m_last     = 0;
    m_err      = 0;
    m_data     = 8'h00;
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit fault;
    int p;
    fault = 0;
    if (m_owner < 0) begin
      p = rr_pick();
      if (p >= 0) begin
        m_owner = p;
        m_want  = 1;
        m_stall = 0;
      end
    end else if (m_want) begin
      if (!tx_busy && req_valid[m_owner]) begin
        m_data  = req_data[8*m_owner +: 8];
        m_last  = req_last[m_owner];
        m_start = 1;
        m_want  = 0;
        head[m_owner]++;
      end else if (m_stall == TO - 1) fault = 1;
      else m_stall++;
    end else if (m_start) begin
      m_start    = 0;
      m_inflight = 1;
      m_stall    = 0;
    end else if (m_inflight) begin
      if (tx_done) begin
        m_inflight = 0;
        if (m_last) begin
          m_ptr   = m_owner;
          m_owner = -1;
        end else begin
          m_want  = 1;
          m_stall = 0;
        end
      end else if (m_stall == TO - 1) fault = 1;
      else m_stall++;
    end
    if (fault) begin
      m_err      = 1;
      m_ptr      = m_owner;
      m_owner    = -1;
      m_want     = 0;
      m_inflight = 0;
    end
  endtask

  task automatic engine_step(input bit started);
    p_done = 0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        p_busy = 0;
        p_done = !silent;
      end else p_busy = 1;
    end else begin
      p_busy = noise && ($urandom_range(3) == 0);
    end
    if (started) begin
      eng_cnt = rand_lat ? $urandom_range(14, 2) : lat_fix;
      p_busy  = 1;
    end
    // stray done pulses while the arbiter is not waiting
    if (spur && eng_cnt == 0 && !m_inflight && !p_done
        && $urandom_range(7) == 0)
      p_done = 1;
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    eg = (m_owner >= 0) ? (one << m_owner) : '0;
    er = (m_owner >= 0 && m_want && !tx_busy) ? eg : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("ready", 32'(req_ready), 32'(er));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  task automatic cycle();
    bit started;
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    compare();
    if (tx_start === 1'b1) sent.push_back(tx_data);
    started = m_start;
    model_step();
    engine_step(started);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    eng_cnt = 0;
    p_busy  = 0;
    p_done  = 0;
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_sent(input int n, input int lim,
                           input string nm);
    int k;
    k = 0;
    while (sent.size() < n && k < lim) begin
      cycle();
      k++;
    end
    chk(nm, 32'(sent.size()), 32'(n));
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int k;
    k = 0;
    while ((!empty_all() || m_owner >= 0) && k < lim) begin
      cycle();
      k++;
    end
    cycle();
    chk(nm, 32'(grant), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rand_lat = 0;
    lat_fix  = 10;
    silent   = 0;
    noise    = 0;
    spur     = 0;
    do_reset();

    // single byte from requester 0
    push(0, 1'b1, 8'h41);
    cycle();
    cycle();
    chk("sb_grant", 32'(grant), 32'h1);
    chk("sb_ready", 32'(req_ready), 32'h1);
    cycle();
    chk("sb_start", 32'(tx_start), 1);
    chk("sb_data", 32'(tx_data), 32'h41);
    repeat (11) cycle();
    chk("sb_done", 32'(tx_done), 1);
    chk("sb_hold", 32'(grant), 32'h1);
    cycle();
    chk("sb_release", 32'(grant), 0);

    // round robin from a fresh reset
    do_reset();
    sent.delete();
    rand_lat = 1;
    push(0, 1'b1, 8'hA0);
    push(0, 1'b1, 8'hA0);
    push(1, 1'b1, 8'hB1);
    push(1, 1'b1, 8'hB1);
    wait_sent(4, 300, "rr_count");
    chk("rr_0", 32'(sent[0]), 32'hA0);
    chk("rr_1", 32'(sent[1]), 32'hB1);
    chk("rr_2", 32'(sent[2]), 32'hA0);
    chk("rr_3", 32'(sent[3]), 32'hB1);
    wait_idle(100, "rr_idle");

    // packet lock with busy noise
    sent.delete();
    noise = 1;
    push(1, 1'b0, 8'h10);
    push(1, 1'b0, 8'h11);
    push(1, 1'b1, 8'h12);
    cycle();
    push(0, 1'b1, 8'h05);
    wait_sent(4, 400, "pk_count");
    chk("pk_0", 32'(sent[0]), 32'h10);
    chk("pk_1", 32'(sent[1]), 32'h11);
    chk("pk_2", 32'(sent[2]), 32'h12);
    chk("pk_3", 32'(sent[3]), 32'h05);
    wait_idle(100, "pk_idle");

    // random traffic with stray done pulses
    spur = 1;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (head[i] == tail[i] && $urandom_range(3) == 0) begin
          int len;
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++)
            push(i, b == len - 1, 8'($urandom_range(255)));
        end
      end
      cycle();
    end
    wait_idle(400, "rnd_idle");
    spur  = 0;
    noise = 0;

    // done exactly on the watchdog limit
    sent.delete();
    rand_lat = 0;
    lat_fix  = 15;
    push(0, 1'b1, 8'h5A);
    wait_sent(1, 50, "tie_sent");
    wait_idle(50, "tie_idle");
    chk("tie_err", 32'(timeout_err), 0);

    // silent transmitter
    sent.delete();
    silent  = 1;
    lat_fix = 5;
    push(1, 1'b1, 8'h77);
    wait_sent(1, 50, "wd_sent");
    repeat (16) cycle();
    chk("wd_pre_err", 32'(timeout_err), 0);
    chk("wd_pre_grant", 32'(grant), 32'h2);
    cycle();
    chk("wd_err", 32'(timeout_err), 1);
    chk("wd_grant", 32'(grant), 0);
    silent = 0;
    push(0, 1'b1, 8'h33);
    wait_sent(2, 50, "wd_after_sent");
    wait_idle(50, "wd_after_idle");
    chk("wd_after_data", 32'(sent[1]), 32'h33);
    chk("wd_sticky", 32'(timeout_err), 1);

    // owner drops valid mid-packet
    do_reset();
    sent.delete();
    rand_lat = 1;
    push(1, 1'b0, 8'h44);
    wait_sent(1, 50, "drop_sent");
    begin
      int k;
      k = 0;
      while (grant !== '0 && k < 100) begin
        cycle();
        k++;
      end
    end
    chk("drop_err", 32'(timeout_err), 1);
    chk("drop_grant", 32'(grant), 0);

    // asynchronous reset while waiting for done
    sent.delete();
    push(0, 1'b1, 8'hC3);
    wait_sent(1, 50, "mr_sent");
    cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_grant", 32'(grant), 0);
    chk("mr_ready", 32'(req_ready), 0);
    chk("mr_start", 32'(tx_start), 0);
    chk("mr_data", 32'(tx_data), 0);
    chk("mr_err", 32'(timeout_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
